// File: rtl/vector_mem_sequencer.sv
// Memory-stage sequencer: turns one 4x16-bit vector load/store into eight byte
// accesses on a byte-wide data memory, stalling upstream stages until done.
module vector_mem_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              VecStoreM,
  input  logic              VecLoadM,
  input  logic [WIDTH-1:0]  AddrM,
  input  logic [3:0][15:0]  VectorWriteDataM,
  input  logic [7:0]        MemReadData,
  output logic [WIDTH-1:0]  MemAddr,
  output logic [7:0]        MemWriteData,
  output logic              MemWrite,
  output logic [3:0][15:0]  VectorReadDataM,
  output logic              StallM,
  output logic              DoneM
);
  typedef enum logic [2:0] {IDLE, STORE, LOAD, DRAIN, DONE} state_t;

  state_t           state_reg;
  logic [2:0]       k_reg;
  logic [2:0]       k_next;
  logic [WIDTH-1:0] base_reg;
  logic [63:0]      store_reg;
  logic [7:0]       store_bytes [8];
  logic [7:0]       shadow_reg [7];
  logic [63:0]      load_vec;

  assign k_next = k_reg + 3'd1;

  // Byte k of a vector is lane k/2, low byte first (little-endian per lane).
  for (genvar gi = 0; gi < 8; gi++) begin : g_store_bytes
    assign store_bytes[gi] = store_reg[gi*8 +: 8];
  end

  // The last byte arrives during DRAIN and bypasses the shadow buffer.
  for (genvar gi = 0; gi < 7; gi++) begin : g_load_vec
    assign load_vec[gi*8 +: 8] = shadow_reg[gi];
  end
  assign load_vec[63:56] = MemReadData;

  always_comb begin
    StallM = 1'b0;
    case (state_reg)
      IDLE:               StallM = VecStoreM | VecLoadM;
      STORE, LOAD, DRAIN: StallM = 1'b1;
      default:            StallM = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= IDLE;
      k_reg           <= 3'd0;
      base_reg        <= '0;
      store_reg       <= '0;
      MemAddr         <= '0;
      MemWriteData    <= 8'h00;
      MemWrite        <= 1'b0;
      VectorReadDataM <= '0;
      DoneM           <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          k_reg <= 3'd0;
          if (VecStoreM) begin
            state_reg    <= STORE;
            base_reg     <= AddrM;
            store_reg    <= VectorWriteDataM;
            MemWrite     <= 1'b1;
            MemAddr      <= AddrM;
            MemWriteData <= VectorWriteDataM[0][7:0];
          end else if (VecLoadM) begin
            state_reg <= LOAD;
            base_reg  <= AddrM;
            MemAddr   <= AddrM;
          end
        end
        STORE: begin
          if (k_reg == 3'd7) begin
            state_reg    <= DONE;
            MemWrite     <= 1'b0;
            MemAddr      <= '0;
            MemWriteData <= 8'h00;
            DoneM        <= 1'b1;
          end else begin
            k_reg        <= k_next;
            MemAddr      <= base_reg + WIDTH'(k_next);
            MemWriteData <= store_bytes[k_next];
          end
        end
        LOAD: begin
          // Read data lags the address by one cycle.
          if (k_reg != 3'd0) shadow_reg[k_reg - 3'd1] <= MemReadData;
          if (k_reg == 3'd7) begin
            state_reg <= DRAIN;
            MemAddr   <= '0;
          end else begin
            k_reg   <= k_next;
            MemAddr <= base_reg + WIDTH'(k_next);
          end
        end
        DRAIN: begin
          VectorReadDataM <= load_vec;
          DoneM           <= 1'b1;
          state_reg       <= DONE;
        end
        DONE: begin
          // Requests still present here belong to the instruction just finished.
          DoneM     <= 1'b0;
          k_reg     <= 3'd0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_vector_mem_sequencer.sv
// Self-checking bench for vector_mem_sequencer: byte-memory model plus a
// reference model of memory contents and the expected per-cycle bus activity.
module tb_vector_mem_sequencer;
  logic             clk = 1'b0;
  logic             reset;
  logic             VecStoreM, VecLoadM;
  logic [7:0]       AddrM;
  logic [3:0][15:0] VectorWriteDataM;
  logic [7:0]       MemReadData;
  logic [7:0]       MemAddr;
  logic [7:0]       MemWriteData;
  logic             MemWrite;
  logic [3:0][15:0] VectorReadDataM;
  logic             StallM, DoneM;

  logic [7:0]  mem [256];
  logic [7:0]  ref_mem [256];
  logic        fill_en = 1'b0;
  logic [7:0]  fill_addr, fill_data;
  logic [63:0] ref_vread;
  int          errors = 0;
  int          checks = 0;

  vector_mem_sequencer #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .VecStoreM(VecStoreM), .VecLoadM(VecLoadM),
    .AddrM(AddrM), .VectorWriteDataM(VectorWriteDataM), .MemReadData(MemReadData),
    .MemAddr(MemAddr), .MemWriteData(MemWriteData), .MemWrite(MemWrite),
    .VectorReadDataM(VectorReadDataM), .StallM(StallM), .DoneM(DoneM)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (fill_en) mem[fill_addr] <= fill_data;
    else if (MemWrite) mem[MemAddr] <= MemWriteData;
    MemReadData <= mem[MemAddr];
  end

  // Drives one request (entered at posedge+1) and checks every cycle until the
  // IDLE cycle after DONE. The model derives bytes as AddrM+k <- byte k.
  task automatic run_op(input logic st, input logic ld, input logic [7:0] addr,
                        input logic [63:0] wdata, input bit drop_early);
    bit          is_store, is_load, exp_we;
    int          last, bi;
    logic [63:0] exp_vread, exp_now;
    logic [7:0]  a, exp_addr, exp_wd;
    is_store  = st;
    is_load   = !st && ld;
    last      = is_store ? 9 : 10;
    exp_vread = ref_vread;
    for (int k = 0; k < 8; k++) begin
      a = addr + 8'(k);
      if (is_store) ref_mem[a] = wdata[k*8 +: 8];
      else if (is_load) exp_vread[k*8 +: 8] = ref_mem[a];
    end
    VecStoreM = st; VecLoadM = ld; AddrM = addr; VectorWriteDataM = wdata;
    for (int c = 0; c <= last; c++) begin
      #1;
      bi       = (c >= 1 && c <= 8) ? c - 1 : 0;
      exp_we   = is_store && c >= 1 && c <= 8;
      exp_addr = (c >= 1 && c <= 8) ? addr + 8'(bi) : 8'h00;
      exp_wd   = exp_we ? wdata[bi*8 +: 8] : 8'h00;
      exp_now  = (c == last) ? exp_vread : ref_vread;
      checks++;
      if (StallM !== (c < last)) begin
        errors++; $display("FAIL stall cycle=%0d got=%b exp=%b", c, StallM, c < last);
      end
      checks++;
      if (DoneM !== (c == last)) begin
        errors++; $display("FAIL done cycle=%0d got=%b exp=%b", c, DoneM, c == last);
      end
      checks++;
      if (MemWrite !== exp_we) begin
        errors++; $display("FAIL memwrite cycle=%0d got=%b exp=%b", c, MemWrite, exp_we);
      end
      checks++;
      if (MemAddr !== exp_addr) begin
        errors++; $display("FAIL memaddr cycle=%0d got=%h exp=%h", c, MemAddr, exp_addr);
      end
      checks++;
      if (MemWriteData !== exp_wd) begin
        errors++; $display("FAIL memwdata cycle=%0d got=%h exp=%h", c, MemWriteData, exp_wd);
      end
      checks++;
      if (VectorReadDataM !== exp_now) begin
        errors++; $display("FAIL vread cycle=%0d got=%h exp=%h", c, VectorReadDataM, exp_now);
      end
      if (drop_early && c == 1) begin
        VecStoreM = 1'b0; VecLoadM = 1'b0;
      end
      if (c < last) @(posedge clk);
    end
    @(posedge clk);
    #1;
    VecStoreM = 1'b0; VecLoadM = 1'b0;
    #1;
    checks++;
    if (StallM !== 1'b0 || DoneM !== 1'b0 || MemWrite !== 1'b0) begin
      errors++; $display("FAIL post_done_idle got stall=%b done=%b we=%b exp=0/0/0",
                         StallM, DoneM, MemWrite);
    end
    ref_vread = exp_vread;
    $display("op st=%b ld=%b addr=%h wdata=%h vread=%h", st, ld, addr, wdata, VectorReadDataM);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; VecStoreM = 1'b0; VecLoadM = 1'b0; AddrM = 8'h00;
    VectorWriteDataM = '0; fill_en = 1'b1;
    for (int i = 0; i < 256; i++) begin
      fill_addr  = 8'(i);
      fill_data  = 8'($urandom);
      ref_mem[i] = fill_data;
      @(posedge clk);
      #1;
    end
    fill_en = 1'b0;
    reset   = 1'b0;
    ref_vread = '0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (MemWrite !== 1'b0 || MemAddr !== 8'h00 || MemWriteData !== 8'h00 ||
          DoneM !== 1'b0 || StallM !== 1'b0 || VectorReadDataM !== 64'h0) begin
        errors++; $display("FAIL reset_idle got we=%b addr=%h wd=%h done=%b stall=%b vread=%h exp=all zero",
                           MemWrite, MemAddr, MemWriteData, DoneM, StallM, VectorReadDataM);
      end
      @(posedge clk);
      #1;
    end
    $display("reset done, memory filled");
  endtask

  task automatic test_store;
    logic [7:0] exp_b [8];
    exp_b = '{8'h33, 8'h44, 8'h11, 8'h22, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    run_op(1'b1, 1'b0, 8'h10, 64'hDDCC_BBAA_2211_4433, 1'b0);
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (mem[8'h10 + 8'(k)] !== exp_b[k]) begin
        errors++; $display("FAIL store_byte k=%0d got=%h exp=%h", k, mem[8'h10 + 8'(k)], exp_b[k]);
      end
    end
  endtask

  task automatic test_load;
    run_op(1'b0, 1'b1, 8'h10, 64'h0, 1'b0);
    checks++;
    if (VectorReadDataM !== 64'hDDCC_BBAA_2211_4433) begin
      errors++; $display("FAIL load_value got=%h exp=ddccbbaa22114433", VectorReadDataM);
    end
  endtask

  task automatic test_wrap;
    logic [63:0] d;
    d = {$urandom, $urandom};
    run_op(1'b1, 1'b0, 8'hFC, d, 1'b0);
    checks++;
    if (mem[8'h00] !== d[39:32] || mem[8'hFF] !== d[31:24]) begin
      errors++; $display("FAIL wrap_bytes got=%h/%h exp=%h/%h", mem[8'hFF], mem[8'h00], d[31:24], d[39:32]);
    end
    run_op(1'b0, 1'b1, 8'hFC, 64'h0, 1'b0);
    checks++;
    if (VectorReadDataM !== d) begin
      errors++; $display("FAIL wrap_roundtrip got=%h exp=%h", VectorReadDataM, d);
    end
  endtask

  task automatic test_both;
    logic [63:0] prev, d;
    prev = ref_vread;
    d    = {$urandom, $urandom};
    run_op(1'b1, 1'b1, 8'h40, d, 1'b0);
    checks++;
    if (VectorReadDataM !== prev) begin
      errors++; $display("FAIL both_vread_kept got=%h exp=%h", VectorReadDataM, prev);
    end
  endtask

  task automatic test_drop;
    run_op(1'b1, 1'b0, 8'h80, {$urandom, $urandom}, 1'b1);
    run_op(1'b0, 1'b1, 8'h80, 64'h0, 1'b1);
  endtask

  task automatic test_reset_mid_load;
    logic [7:0] a;
    a = 8'h20;
    VecLoadM = 1'b1; AddrM = a;
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk);
      #1;
      checks++;
      if (MemWrite !== 1'b0 || MemAddr !== a + 8'(c - 1)) begin
        errors++; $display("FAIL midload cycle=%0d got we=%b addr=%h exp we=0 addr=%h",
                           c, MemWrite, MemAddr, a + 8'(c - 1));
      end
    end
    reset = 1'b1; VecLoadM = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    ref_vread = '0;
    checks++;
    if (StallM !== 1'b0 || MemWrite !== 1'b0 || MemAddr !== 8'h00 ||
        DoneM !== 1'b0 || VectorReadDataM !== 64'h0) begin
      errors++; $display("FAIL reset_mid_load got stall=%b we=%b addr=%h done=%b vread=%h exp=all zero",
                         StallM, MemWrite, MemAddr, DoneM, VectorReadDataM);
    end
    for (int c = 0; c < 12; c++) begin
      @(posedge clk);
      #1;
      checks++;
      if (DoneM !== 1'b0 || MemWrite !== 1'b0 || StallM !== 1'b0) begin
        errors++; $display("FAIL after_reset cycle=%0d got done=%b we=%b stall=%b exp=0/0/0",
                           c, DoneM, MemWrite, StallM);
      end
    end
    $display("reset asserted during load k=4");
  endtask

  task automatic test_random;
    logic [7:0] a;
    bit         st;
    for (int i = 0; i < 10; i++) begin
      st = 1'($urandom_range(0, 1));
      a  = ($urandom_range(0, 2) == 0) ? 8'hF8 + 8'($urandom_range(0, 7)) : 8'($urandom);
      run_op(st, !st, a, {$urandom, $urandom}, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_store();
    test_load();
    test_wrap();
    test_both();
    test_drop();
    test_reset_mid_load();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/vector_mem_sequencer.md
# vector_mem_sequencer

Memory-stage companion to the execute stage. Takes the scalar ALU result as a base address and either the execute-stage vector operand (store) or a destination buffer (load). It serialises a 4-lane × 16-bit vector access into eight byte accesses on the byte-wide data memory. It stalls the pipeline for the duration and presents a fully assembled vector when done.

## Interface
- WIDTH, 8, scalar datapath and byte-address width; addresses wrap modulo 2^WIDTH
- clk  input  1  single clock, rising-edge
- reset  input  1  synchronous, active-high
- VecStoreM  input  1  vector store request (held by pipeline while StallM=1)
- VecLoadM  input  1  vector load request (held by pipeline while StallM=1)
- AddrM  input  WIDTH  base byte address (ALU result)
- VectorWriteDataM  input  [3:0][15:0]  store data, lane 0 = [0]
- MemReadData  input  8  data memory read byte, valid the cycle after MemAddr
- MemAddr  output  WIDTH  data memory byte address
- MemWriteData  output  8  byte to write
- MemWrite  output  1  write strobe, one byte per cycle
- VectorReadDataM  output  [3:0][15:0]  assembled load result, held until next load completes
- StallM  output  1  freeze upstream stages
- DoneM  output  1  one-cycle pulse: access complete

## Operation
- Byte layout is little-endian per lane. Byte k (k=0..7) is at AddrM+k (mod 2^WIDTH). It is lane k/2, low byte when k is even.
- States: IDLE, STORE, LOAD, DRAIN, DONE. A 3-bit byte counter k and registered base address/store data.
- IDLE: StallM = VecStoreM | VecLoadM (combinational). On an edge with VecStoreM=1, latch AddrM and VectorWriteDataM, set k=0, go STORE. Else on an edge with VecLoadM=1, latch AddrM, set k=0, go LOAD. If both are high, store wins and the load is dropped.
- STORE: MemWrite=1, MemAddr=base+k, MemWriteData=byte k. k increments each cycle. When k=7 go DONE.
- LOAD: MemWrite=0, MemAddr=base+k. For k≥1, capture MemReadData into byte k−1 of the shadow buffer. When k=7 go DRAIN.
- DRAIN: capture MemReadData into byte 7. Copy the buffer to VectorReadDataM. Go DONE.
- DONE: StallM=0, DoneM=1, MemWrite=0. Requests are ignored, because they are the same instruction still on the inputs. Always go IDLE.
- VectorReadDataM changes only on the DRAIN→DONE edge. A store never alters it.
- Outside STORE/LOAD, MemAddr=0, MemWriteData=0, MemWrite=0.

## Timing
- Reset values: state IDLE, k=0, MemWrite=0, MemAddr=0, MemWriteData=0, VectorReadDataM=0, DoneM=0. StallM=0 while no request.
- Store: request in cycle 0 (IDLE, stall high), writes in cycles 1–8, DONE in cycle 9. StallM is high for 9 cycles.
- Load: request in cycle 0, addresses in cycles 1–8, final capture in cycle 9 (DRAIN), DONE plus valid data in cycle 10. StallM is high for 10 cycles.
- Back-to-back: a new request is accepted no earlier than the IDLE cycle after DONE. Minimum spacing is 10 cycles (store) or 11 cycles (load).
- Address wrap: base 0xFC gives bytes at FC, FD, FE, FF, 00, 01, 02, 03.
- Reset mid-operation: return to IDLE at that edge. MemWrite is low from the next cycle. Bytes already written are not rolled back. VectorReadDataM is cleared to 0. No DoneM pulse.
- Request deasserted mid-operation: ignored; the sequence runs to completion.

## Test plan
- Reset, then idle. Expect all outputs 0 and StallM=0.
- Store AddrM=0x10, data {0xDDCC,0xBBAA,0x2211,0x4433} (lanes 3..0). Expect writes 10:33, 11:44, 12:11, 13:22, 14:AA, 15:BB, 16:CC, 17:DD in cycles 1–8, StallM high 9 cycles, DoneM in cycle 9.
- Load AddrM=0x10 from the same memory model. Expect VectorReadDataM == stored vector at cycle 10, StallM high 10 cycles, one DoneM pulse.
- Wrap: store, then load at AddrM=0xFC. Expect addresses FC..03 in order and round-trip data equal.
- VecStoreM and VecLoadM high together. Expect the store sequence only and VectorReadDataM unchanged.
- Assert reset during LOAD k=4. Expect IDLE next cycle, VectorReadDataM=0, no DoneM pulse, MemWrite=0 throughout.
